// File: rtl/dds_pkg.sv
// Shared encodings, widths and state type for the DDS wave sequencer and its SPI register block.
package dds_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 6;
  localparam int DATA_W_DEF  = 9;
  localparam int OUT_W_DEF   = DATA_W_DEF + 1;
  localparam int IDX_W       = ADDR_W_DEF + 2;

  localparam logic [1:0] WAVE_TRI = 2'b00;
  localparam logic [1:0] WAVE_SQR = 2'b01;
  localparam logic [1:0] WAVE_SAW = 2'b10;
  localparam logic [1:0] WAVE_OFF = 2'b11;

  localparam logic [OUT_W_DEF-1:0] MIDSCALE = 10'h200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dds_quadrant_fold.sv
// Maps a full-period index onto the quarter-wave table and rebuilds the signed-about-midscale
// triangle sample from the returned table word.
module dds_quadrant_fold
  import dds_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 9,
  parameter int OUT_W  = DATA_W + 1
) (
  input  logic [ADDR_W+1:0] idx,
  input  logic [DATA_W-1:0] tab_data,
  output logic [ADDR_W-1:0] tab_addr,
  output logic [OUT_W-1:0]  tri_sample
);

  localparam logic [OUT_W-1:0] MID    = OUT_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] MID_M1 = MID - OUT_W'(1);

  logic [OUT_W-1:0] tab_ext;

  // Odd quadrants read the table backwards (~a == 63-a); the upper half mirrors below midscale.
  always_comb begin
    tab_addr   = idx[ADDR_W] ? ~idx[ADDR_W-1:0] : idx[ADDR_W-1:0];
    tab_ext    = OUT_W'(tab_data);
    tri_sample = idx[ADDR_W+1] ? (MID_M1 - tab_ext) : (MID + tab_ext);
  end

endmodule

// File: rtl/dds_wave_ctrl.sv
// DDS sequencer: phase accumulator, double-buffered settings applied at period wrap,
// waveform select and a single registered DAC output stage.
module dds_wave_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 9,
  parameter int OUT_W   = DATA_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PHASE_W-1:0]  cfg_freq,
  input  logic [7:0]          cfg_poff,
  input  logic [1:0]          cfg_wave,
  output logic [ADDR_W-1:0]   tab_addr,
  input  logic [DATA_W-1:0]   tab_data,
  output logic [OUT_W-1:0]    dac_data,
  output logic                dac_valid,
  output logic                wrap,
  output logic                busy
);

  localparam int               IW  = ADDR_W + 2;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] acc, freq_a, freq_s;
  logic [IW-1:0]      poff_a, poff_s, idx;
  logic [1:0]         wave_a, wave_s;
  logic               shadow_full, accept, apply, quiet, wrap_c;
  logic [PHASE_W:0]   sum;
  logic [OUT_W-1:0]   tri_s, sample, dac_data_p1;
  logic               vld_p1;

  dds_quadrant_fold #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_fold (
    .idx        (idx),
    .tab_data   (tab_data),
    .tab_addr   (tab_addr),
    .tri_sample (tri_s)
  );

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, freq_a};
    wrap_c = (state != IDLE) && sum[PHASE_W];
    idx    = acc[PHASE_W-1 -: IW] + poff_a;
    accept = cfg_valid && !shadow_full;
    apply  = shadow_full && ((state == IDLE) || wrap_c);

    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)                              state_nxt = RUN;
        else if (wrap_c || (freq_a == '0))    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Output goes quiet both while idling and on the edge that enters IDLE.
    quiet = (state == IDLE) || (state_nxt == IDLE);

    case (wave_a)
      WAVE_TRI: sample = tri_s;
      WAVE_SQR: sample = idx[IW-1] ? '0 : '1;
      WAVE_SAW: sample = OUT_W'(idx) << (OUT_W - IW);
      default:  sample = MID;
    endcase
  end

  // Stage p0 -> p1: control state, accumulator and registered DAC sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      freq_a      <= '0;
      poff_a      <= '0;
      wave_a      <= WAVE_TRI;
      shadow_full <= 1'b0;
      dac_data_p1 <= MID;
      vld_p1      <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= quiet ? '0 : sum[PHASE_W-1:0];
      if (accept) begin
        shadow_full <= 1'b1;
      end else if (apply) begin
        shadow_full <= 1'b0;
        freq_a      <= freq_s;
        poff_a      <= poff_s;
        wave_a      <= wave_s;
      end
      dac_data_p1 <= quiet ? MID : sample;
      vld_p1      <= !quiet;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      freq_s <= cfg_freq;
      poff_s <= cfg_poff;
      wave_s <= cfg_wave;
    end
  end

  assign cfg_ready = !shadow_full;
  assign wrap      = wrap_c;
  assign busy      = (state != IDLE);
  assign dac_data  = dac_data_p1;
  assign dac_valid = vld_p1;

endmodule
